// File: rtl/tri_outline_gen_pkg.sv
// Shared constants, state encoding and row helper for the triangle outline generator.
package tri_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 600;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t PARK_X = COORD_W'(801);
  localparam coord_t PARK_Y = COORD_W'(601);

  typedef enum logic [1:0] {IDLE, DIV, EMIT, DONE} state_t;

  // Leftmost pixel of a row: full span on the horizontal leg, else {x1, xh}.
  function automatic coord_t row_first_x(coord_t y, coord_t y2, coord_t x1, coord_t x2,
                                         coord_t xh);
    if (y == y2) return (x1 < x2) ? x1 : x2;
    return (x1 < xh) ? x1 : xh;
  endfunction

endpackage

// File: rtl/tri_outline_gen_udiv10.sv
// Restoring unsigned divider, one quotient bit per clock, valid pulses after the last bit.
module udiv10
  import tri_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] dividend,
  input  logic [COORD_W-1:0] divisor,
  output logic [COORD_W-1:0] quotient,
  output logic [COORD_W-1:0] remainder,
  output logic               valid
);

  logic [COORD_W-1:0] den;
  logic [3:0]         cnt;
  logic               busy;
  logic [COORD_W:0]   trial;

  // Dividend bits shift out of the quotient register as quotient bits shift in.
  always_comb trial = {remainder, quotient[COORD_W-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      den       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      den       <= divisor;
      cnt       <= '0;
      busy      <= 1'b1;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (busy) begin
        if (trial >= {1'b0, den}) begin
          remainder <= COORD_W'(trial - {1'b0, den});
          quotient  <= {quotient[COORD_W-2:0], 1'b1};
        end else begin
          remainder <= trial[COORD_W-1:0];
          quotient  <= {quotient[COORD_W-2:0], 1'b0};
        end
        cnt <= cnt + 4'd1;
        if (cnt == 4'(COORD_W - 1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tri_outline_gen.sv
// Presents the outline of the right triangle P1, P2, (x1,y2) one pixel at a time in scan order.
module tri_outline_gen
  import tri_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               draw_enable,
  input  logic               renew_output,
  input  logic               end_frame,
  input  logic [COORD_W-1:0] i_X_pos_1,
  input  logic [COORD_W-1:0] i_Y_pos_1,
  input  logic [COORD_W-1:0] i_X_pos_2,
  input  logic [COORD_W-1:0] i_Y_pos_2,
  output logic [COORD_W-1:0] o_X_pos,
  output logic [COORD_W-1:0] o_Y_pos,
  output logic               done
);

  state_t                    state;
  coord_t                    x1, y1, x2, y2, q_r, r_r, err;
  logic signed [COORD_W:0]   xh;

  logic                      in_ok, div_start, div_valid;
  coord_t                    in_dx, in_dy, div_q, div_r;
  logic                      up, sx_neg, row_end, last_px, restart;
  coord_t                    ytop, ybot, x_start, x_end, dy_l, init_x;
  coord_t                    row_hi, nxt_x, nxt_y, walk_err;
  logic signed [COORD_W:0]   xh_step, walk_xh;
  logic [COORD_W:0]          err_sum;

  // The divider is loaded straight from the ports on the draw_enable edge.
  always_comb begin
    in_ok = (i_X_pos_1 < COORD_W'(H_ACTIVE)) && (i_X_pos_2 < COORD_W'(H_ACTIVE)) &&
            (i_Y_pos_1 < COORD_W'(V_ACTIVE)) && (i_Y_pos_2 < COORD_W'(V_ACTIVE));
    in_dx = (i_X_pos_2 >= i_X_pos_1) ? i_X_pos_2 - i_X_pos_1 : i_X_pos_1 - i_X_pos_2;
    in_dy = (i_Y_pos_2 >= i_Y_pos_1) ? i_Y_pos_2 - i_Y_pos_1 : i_Y_pos_1 - i_Y_pos_2;
    div_start = draw_enable && in_ok;
  end

  udiv10 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (in_dx),
    .divisor   (in_dy),
    .quotient  (div_q),
    .remainder (div_r),
    .valid     (div_valid)
  );

  // Hypotenuse runs from the vertex on the top row to the other vertex.
  always_comb begin
    up      = (y1 <= y2);
    ytop    = up ? y1 : y2;
    ybot    = up ? y2 : y1;
    x_start = up ? x1 : x2;
    x_end   = up ? x2 : x1;
    sx_neg  = (x_end < x_start);
    dy_l    = ybot - ytop;
    init_x  = row_first_x(ytop, y2, x1, x2, x_start);

    xh_step  = sx_neg ? xh - $signed({1'b0, q_r}) : xh + $signed({1'b0, q_r});
    err_sum  = {1'b0, err} + {1'b0, r_r};
    walk_xh  = xh_step;
    walk_err = err_sum[COORD_W-1:0];
    if (err_sum >= {1'b0, dy_l}) begin
      walk_xh  = sx_neg ? xh_step - 11'sd1 : xh_step + 11'sd1;
      walk_err = COORD_W'(err_sum - {1'b0, dy_l});
    end

    if (o_Y_pos == y2) row_hi = (x1 > x2) ? x1 : x2;
    else               row_hi = (x1 > xh[COORD_W-1:0]) ? x1 : xh[COORD_W-1:0];
    row_end = (o_X_pos == row_hi);
    last_px = row_end && (o_Y_pos == ybot);
    nxt_y   = o_Y_pos + 10'd1;
    nxt_x   = row_first_x(nxt_y, y2, x1, x2, walk_xh[COORD_W-1:0]);

    restart = ((state == DIV) && ((dy_l == '0) || div_valid)) ||
              (((state == EMIT) || (state == DONE)) && end_frame);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x1      <= '0;
      y1      <= '0;
      x2      <= '0;
      y2      <= '0;
      q_r     <= '0;
      r_r     <= '0;
      xh      <= '0;
      err     <= '0;
      o_X_pos <= PARK_X;
      o_Y_pos <= PARK_Y;
      done    <= 1'b1;
    end else if (draw_enable) begin
      o_X_pos <= PARK_X;
      o_Y_pos <= PARK_Y;
      if (in_ok) begin
        x1    <= i_X_pos_1;
        y1    <= i_Y_pos_1;
        x2    <= i_X_pos_2;
        y2    <= i_Y_pos_2;
        state <= DIV;
        done  <= 1'b0;
      end else begin
        state <= IDLE;
        done  <= 1'b1;
      end
    end else if (restart) begin
      // Slope is committed only out of DIV; a frame rewind keeps q and r.
      if (state == DIV) begin
        q_r <= (dy_l == '0) ? '0 : div_q;
        r_r <= (dy_l == '0) ? '0 : div_r;
      end
      xh      <= $signed({1'b0, x_start});
      err     <= '0;
      o_X_pos <= init_x;
      o_Y_pos <= ytop;
      done    <= 1'b0;
      state   <= EMIT;
    end else if ((state == EMIT) && renew_output) begin
      if (last_px) begin
        o_X_pos <= PARK_X;
        o_Y_pos <= PARK_Y;
        done    <= 1'b1;
        state   <= DONE;
      end else if (row_end) begin
        xh      <= walk_xh;
        err     <= walk_err;
        o_X_pos <= nxt_x;
        o_Y_pos <= nxt_y;
      end else begin
        o_X_pos <= (o_Y_pos == y2) ? o_X_pos + 10'd1 : row_hi;
      end
    end
  end

endmodule

// File: tb/tb_tri_outline_gen.sv
// Directed bench for tri_outline_gen with hand-computed pixel sequences.
module tb_tri_outline_gen;

  logic       clk = 1'b0;
  logic       rst, draw_enable, renew_output, end_frame;
  logic [9:0] i_X_pos_1, i_Y_pos_1, i_X_pos_2, i_Y_pos_2;
  logic [9:0] o_X_pos, o_Y_pos;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  tri_outline_gen dut (
    .clk          (clk),
    .rst          (rst),
    .draw_enable  (draw_enable),
    .renew_output (renew_output),
    .end_frame    (end_frame),
    .i_X_pos_1    (i_X_pos_1),
    .i_Y_pos_1    (i_Y_pos_1),
    .i_X_pos_2    (i_X_pos_2),
    .i_Y_pos_2    (i_Y_pos_2),
    .o_X_pos      (o_X_pos),
    .o_Y_pos      (o_Y_pos),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_park(input string tag);
    check({tag, "_x"}, 32'(o_X_pos), 32'd801);
    check({tag, "_y"}, 32'(o_Y_pos), 32'd601);
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_px(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(o_X_pos), 32'(x));
    check({tag, "_y"}, 32'(o_Y_pos), 32'(y));
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic push_px(input int x, input int y);
    exp_q.push_back({10'(x), 10'(y)});
  endtask

  task automatic push_span(input int lo, input int hi, input int y);
    for (int x = lo; x <= hi; x++) push_px(x, y);
  endtask

  // Load a figure and check the parked DIV phase up to the first pixel.
  task automatic start_fig(input string tag, input int x1, input int y1, input int x2,
                           input int y2, input int lat);
    i_X_pos_1 = 10'(x1);
    i_Y_pos_1 = 10'(y1);
    i_X_pos_2 = 10'(x2);
    i_Y_pos_2 = 10'(y2);
    draw_enable = 1'b1;
    tick();
    draw_enable = 1'b0;
    check({tag, "_div_done"}, 32'(done), 32'd0);
    check({tag, "_div_x"}, 32'(o_X_pos), 32'd801);
    repeat (lat - 2) tick();
    if (lat > 2) check({tag, "_div_late_x"}, 32'(o_X_pos), 32'd801);
    tick();
  endtask

  // Consume every expected pixel with renew_output held high, then expect parking.
  task automatic walk_fig(input string tag);
    renew_output = 1'b1;
    foreach (exp_q[i]) begin
      check_px($sformatf("%s_p%0d", tag, i), int'(exp_q[i][19:10]), int'(exp_q[i][9:0]));
      tick();
    end
    renew_output = 1'b0;
    check_park({tag, "_end"});
  endtask

  task automatic build_fig_a();
    exp_q.delete();
    push_px(100, 100);
    push_px(100, 101); push_px(102, 101);
    push_px(100, 102); push_px(105, 102);
    push_px(100, 103); push_px(107, 103);
    push_span(100, 110, 104);
  endtask

  initial begin
    rst = 1'b1; draw_enable = 1'b0; renew_output = 1'b0; end_frame = 1'b0;
    i_X_pos_1 = '0; i_Y_pos_1 = '0; i_X_pos_2 = '0; i_Y_pos_2 = '0;
    tick(); tick();
    rst = 1'b0;
    check_park("reset");
    renew_output = 1'b1; tick(); renew_output = 1'b0;
    check_park("idle_renew");
    end_frame = 1'b1; tick(); end_frame = 1'b0;
    check_park("idle_eof");

    build_fig_a();
    check("fig_a_len", 32'(exp_q.size()), 32'd18);
    start_fig("fig_a", 100, 100, 110, 104, 12);
    walk_fig("fig_a");

    // Rewind from DONE, consume five pixels, rewind mid-figure with renew also high.
    end_frame = 1'b1; tick(); end_frame = 1'b0;
    check_px("eof_done", 100, 100);
    renew_output = 1'b1;
    repeat (5) tick();
    check_px("mid_p5", 100, 103);
    end_frame = 1'b1; tick(); end_frame = 1'b0;
    renew_output = 1'b0;
    check_px("eof_mid", 100, 100);
    walk_fig("fig_a_rep");

    exp_q.delete();
    push_span(40, 50, 20);
    start_fig("horiz", 50, 20, 40, 20, 2);
    walk_fig("horiz");

    exp_q.delete();
    push_px(7, 7);
    start_fig("point", 7, 7, 7, 7, 2);
    walk_fig("point");

    // P2 above P1: horizontal leg first, hypotenuse from P2 down to P1.
    exp_q.delete();
    push_span(4, 10, 10);
    push_px(6, 11); push_px(10, 11);
    push_px(8, 12); push_px(10, 12);
    push_px(10, 13);
    start_fig("up", 10, 13, 4, 10, 12);
    walk_fig("up");

    // Hypotenuse stepping left.
    exp_q.delete();
    push_px(20, 0);
    push_px(18, 1); push_px(20, 1);
    push_px(16, 2); push_px(20, 2);
    push_span(14, 20, 3);
    start_fig("neg", 20, 0, 14, 3, 12);
    walk_fig("neg");

    i_X_pos_1 = 10'd100; i_Y_pos_1 = 10'd100; i_X_pos_2 = 10'd801; i_Y_pos_2 = 10'd601;
    draw_enable = 1'b1; tick(); draw_enable = 1'b0;
    check_park("bad_coords");
    end_frame = 1'b1; tick(); end_frame = 1'b0;
    check_park("bad_eof");

    start_fig("reload", 100, 100, 110, 104, 12);
    check_px("reload_p0", 100, 100);
    renew_output = 1'b1;
    tick(); tick();
    check_px("reload_p2", 102, 101);
    rst = 1'b1; tick(); rst = 1'b0;
    check_park("rst_mid");
    tick();
    check_park("rst_after");
    renew_output = 1'b0;
    end_frame = 1'b1; tick(); end_frame = 1'b0;
    check_park("rst_eof");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
